// File: rtl/vga_pkg.sv
// Display timing constants shared with vga_hvsync_gen, plus RAM word geometry
// used by the VRAM arbiter and its line fetcher.
package vga_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;
    localparam int H_MAX     = 799;
    localparam int V_MAX     = 524;

    localparam int PIX_W  = 4;
    localparam int PPW    = 4;
    localparam int WORD_W = PIX_W * PPW;
    localparam int ADDR_W = 17;

    localparam int WORDS_PER_LINE = H_DISPLAY / PPW;

    typedef enum logic [1:0] {
        SLOT_NONE = 2'd0,
        SLOT_LINE = 2'd1,
        SLOT_NEXT = 2'd2
    } slot_e;

    // Line number the sync generator will present after vpos, wrapping at the frame end.
    function automatic logic [9:0] next_line(input logic [9:0] vpos);
        return (vpos == 10'(V_MAX)) ? 10'd0 : vpos + 10'd1;
    endfunction

endpackage

// File: rtl/vga_line_fetch.sv
// Scan-out side of the VRAM arbiter: decides the fixed display read slots,
// tracks the current line's base word address and turns fetched words into pixels.
module vga_line_fetch
    import vga_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [9:0]        i_hpos,
    input  logic [9:0]        i_vpos,
    input  logic              i_display_on,
    input  logic [WORD_W-1:0] i_mem_rdata,
    output logic              o_disp_slot,
    output logic [ADDR_W-1:0] o_disp_addr,
    output logic [PIX_W-1:0]  o_pix
);

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WORDS_PER_LINE);

    logic [ADDR_W-1:0] r_line_base;
    logic [1:0]        r_slot_pipe;
    logic [WORD_W-1:0] r_hold;
    logic [WORD_W-1:0] r_word_cur;
    logic [PIX_W-1:0]  r_pix;

    slot_e             w_slot;
    logic [9:0]        w_next_v;
    logic [ADDR_W-1:0] w_word_idx;
    logic [PIX_W-1:0]  w_lane [PPW];

    assign w_next_v = next_line(i_vpos);

    always_comb begin
        w_slot = SLOT_NONE;
        if ((i_hpos[1:0] == 2'd0) && (i_hpos <= 10'(H_DISPLAY - 8)) &&
            (i_vpos < 10'(V_DISPLAY))) begin
            w_slot = SLOT_LINE;
        end else if ((i_hpos == 10'(H_MAX - 3)) && (w_next_v < 10'(V_DISPLAY))) begin
            w_slot = SLOT_NEXT;
        end
    end

    // Each in-line slot prefetches the word one group ahead of the one on screen.
    assign w_word_idx = {{(ADDR_W - 8){1'b0}}, i_hpos[9:2]} + ADDR_W'(1);

    always_comb begin
        o_disp_addr = r_line_base + w_word_idx;
        if (w_slot == SLOT_NEXT) begin
            o_disp_addr = (i_vpos == 10'(V_MAX)) ? BASE_ADDR : (r_line_base + LINE_STEP);
        end
    end

    assign o_disp_slot = (w_slot != SLOT_NONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line_base <= BASE_ADDR;
        end else if (i_hpos == 10'(H_MAX)) begin
            if (i_vpos == 10'(V_MAX)) begin
                r_line_base <= BASE_ADDR;
            end else if (i_vpos < 10'(V_DISPLAY - 1)) begin
                r_line_base <= r_line_base + LINE_STEP;
            end
        end
    end

    // Read data returns two cycles after the slot; only display reads are kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_pipe <= '0;
            r_hold      <= '0;
            r_word_cur  <= '0;
        end else begin
            r_slot_pipe <= {r_slot_pipe[0], o_disp_slot};
            if (r_slot_pipe[1]) begin
                r_hold <= i_mem_rdata;
            end
            if (i_hpos[1:0] == 2'd3) begin
                r_word_cur <= r_hold;
            end
        end
    end

    for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
        assign w_lane[gi] = r_word_cur[gi*PIX_W +: PIX_W];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix <= '0;
        end else begin
            r_pix <= i_display_on ? w_lane[i_hpos[1:0]] : '0;
        end
    end

    assign o_pix = r_pix;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port VRAM between scan-out reads and a host port; display wins.
// Define VGA_VRAM_HOST_READ_EN to add host reads (i_host_we, o_host_rdata, o_host_rvalid).
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [9:0]        i_hpos,
    input  logic [9:0]        i_vpos,
    input  logic              i_display_on,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [WORD_W-1:0] i_host_wdata,
`ifdef VGA_VRAM_HOST_READ_EN
    input  logic              i_host_we,
    output logic [WORD_W-1:0] o_host_rdata,
    output logic              o_host_rvalid,
`endif
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic [WORD_W-1:0] i_mem_rdata,
    output logic [PIX_W-1:0]  o_pix_out
);

    logic              w_disp_slot;
    logic [ADDR_W-1:0] w_disp_addr;
    logic              w_accept;
    logic              w_host_we;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;

    vga_line_fetch #(
        .BASE_ADDR (BASE_ADDR)
    ) u_line_fetch (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_hpos       (i_hpos),
        .i_vpos       (i_vpos),
        .i_display_on (i_display_on),
        .i_mem_rdata  (i_mem_rdata),
        .o_disp_slot  (w_disp_slot),
        .o_disp_addr  (w_disp_addr),
        .o_pix        (o_pix_out)
    );

`ifdef VGA_VRAM_HOST_READ_EN
    assign w_host_we = i_host_we;
`else
    assign w_host_we = 1'b1;
`endif

    // Ready is held low through reset so nothing is accepted while state is cleared.
    assign o_host_ready = i_rst_n & ~w_disp_slot;
    assign w_accept     = i_host_valid & o_host_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_disp_slot) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= w_disp_addr;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_host_we;
            r_mem_addr  <= i_host_addr;
            r_mem_wdata <= i_host_wdata;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
        end
    end

    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

`ifdef VGA_VRAM_HOST_READ_EN
    logic [1:0] r_hrd_pipe;

    // Tracks host reads so their data is flagged when it comes back; display reads never are.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hrd_pipe <= '0;
        end else begin
            r_hrd_pipe <= {r_hrd_pipe[0], w_accept & ~w_host_we};
        end
    end

    assign o_host_rvalid = r_hrd_pipe[1];
    assign o_host_rdata  = r_hrd_pipe[1] ? i_mem_rdata : '0;
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Randomized host traffic over scanned frames, checked every cycle against a
// frame/line-level model of the VRAM arbiter, plus directed literal checks.
module tb_vga_vram_arbiter;
    import vga_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [9:0]        hpos, vpos;
    logic              display_on;
    logic              host_valid, host_ready, host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [WORD_W-1:0] host_wdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata = '0;
    logic [PIX_W-1:0]  pix_out;
`ifdef VGA_VRAM_HOST_READ_EN
    logic [WORD_W-1:0] host_rdata;
    logic              host_rvalid;
`endif

    vga_vram_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_hpos       (hpos),
        .i_vpos       (vpos),
        .i_display_on (display_on),
        .i_host_valid (host_valid),
        .o_host_ready (host_ready),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
`ifdef VGA_VRAM_HOST_READ_EN
        .i_host_we    (host_we),
        .o_host_rdata (host_rdata),
        .o_host_rvalid(host_rvalid),
`endif
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_pix_out    (pix_out)
    );

    // Single-port synchronous RAM.
    logic [WORD_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic              m_en = 1'b0, m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [WORD_W-1:0] m_wdata = '0;
    logic [PIX_W-1:0]  m_pix = '0;
    logic              pend_v = 1'b0;
    int                pend_key = 0;
    logic [WORD_W-1:0] fetched [int];
    logic              r1_v = 1'b0, r2_v = 1'b0;
    logic [ADDR_W-1:0] r1_addr = '0;
    logic [WORD_W-1:0] r2_data = '0;

    always @(negedge clk) begin
        int h, v, nv, key;
        logic slot, acc;
        logic [WORD_W-1:0] w;
        h = int'(hpos);
        v = int'(vpos);
        if (!rst_n) begin
            check("rst_host_ready", host_ready, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_pix", pix_out, 0);
`ifdef VGA_VRAM_HOST_READ_EN
            check("rst_rvalid", host_rvalid, 0);
`endif
            m_en = 0; m_we = 0; m_pix = 0;
            pend_v = 0; r1_v = 0; r2_v = 0;
            fetched.delete();
        end else begin
            check("mem_en", mem_en, m_en);
            check("mem_we", mem_we, m_we);
            if (m_en) check("mem_addr", mem_addr, m_addr);
            if (m_en && m_we) check("mem_wdata", mem_wdata, m_wdata);
            check("pix", pix_out, m_pix);
`ifdef VGA_VRAM_HOST_READ_EN
            check("host_rvalid", host_rvalid, r2_v);
            if (r2_v) check("host_rdata", host_rdata, r2_data);
            r2_v = r1_v;
            r2_data = ram[r1_addr];
`endif
            // A read issued last cycle sees the RAM as it stands now.
            if (pend_v) fetched[pend_key] = ram[ADDR_W'(pend_key)];
            pend_v = 0;

            nv = (v == V_MAX) ? 0 : v + 1;
            slot = 0;
            if ((h % 4 == 0) && (h <= H_DISPLAY - 8) && (v < V_DISPLAY)) begin
                slot = 1;
                pend_key = v * WORDS_PER_LINE + h / 4 + 1;
            end else if ((h == H_MAX - 3) && (nv < V_DISPLAY)) begin
                slot = 1;
                pend_key = nv * WORDS_PER_LINE;
            end
            check("host_ready", host_ready, !slot);
            acc = host_valid && !slot;
            m_en = slot || acc;
            m_we = acc && host_we;
            m_addr = slot ? ADDR_W'(pend_key) : host_addr;
            m_wdata = host_wdata;
            pend_v = slot;
            r1_v = acc && !host_we;
            r1_addr = host_addr;

            if (display_on) begin
                key = v * WORDS_PER_LINE + h / 4;
                w = fetched.exists(key) ? fetched[key] : '0;
                m_pix = w[(h % 4) * PIX_W +: PIX_W];
            end else begin
                m_pix = '0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int                host_mode = 0;   // 0 random, 1 idle, 2 forced request
    logic [ADDR_W-1:0] f_addr;
    logic [WORD_W-1:0] f_data;
    logic              f_we;
    logic              hold_req = 1'b0;
    logic              s_ready;

    function automatic logic rand_we();
`ifdef VGA_VRAM_HOST_READ_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b1;
`endif
    endfunction

    task automatic step(input int h, input int v);
        hpos = 10'(h);
        vpos = 10'(v);
        display_on = (h < H_DISPLAY) && (v < V_DISPLAY);
        if (!hold_req) begin
            case (host_mode)
                1: host_valid = 1'b0;
                2: begin
                    host_valid = 1'b1; host_addr = f_addr; host_wdata = f_data; host_we = f_we;
                end
                default: begin
                    host_valid = ($urandom_range(0, 1) == 1);
                    host_addr  = ADDR_W'($urandom_range(8, (1 << ADDR_W) - 1));
                    host_wdata = WORD_W'($urandom);
                    host_we    = rand_we();
                end
            endcase
        end
        @(negedge clk);
        s_ready  = host_ready;
        hold_req = host_valid && !host_ready && rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int fidx);
        for (int h = 0; h <= H_MAX; h++) begin
            host_mode = 0;
`ifdef VGA_VRAM_HOST_READ_EN
            if (fidx == 1) begin
                f_addr = 17'd5; f_data = '0; f_we = 1'b0;
                host_mode = (h == 700) ? 2 : ((h >= 698 && h <= 701) ? 1 : 0);
            end
`endif
            step(h, 0);
            if (h < 8) check($sformatf("pix_line0_h%0d", h), pix_out,
                             (fidx == 0 && h < 4) ? 0 : h);
            if (h == 700) check("pix_blank_h700", pix_out, 0);
`ifdef VGA_VRAM_HOST_READ_EN
            if (fidx == 1 && h == 700) begin
                check("rd_ready_h700", s_ready, 1);
                check("rd_rvalid_early", host_rvalid, 0);
            end
            if (fidx == 1 && h == 701) begin
                check("rd_rvalid", host_rvalid, 1);
                check("rd_rdata", host_rdata, 16'hA5A5);
                $display("host read addr 5 -> %h", host_rdata);
            end
`endif
        end
        for (int h = 0; h <= H_MAX; h++) step(h, 1);
        f_addr = 17'h1ABCD; f_data = 16'h5A3C; f_we = 1'b1;
        for (int h = 0; h <= H_MAX; h++) begin
            host_mode = (h == 2 || h == 3) ? 1 : ((h == 4) ? 2 : 0);
            step(h, 2);
            if (h == 4) begin
                check("slot_ready_h4", s_ready, 0);
                check("slot_en_h4", mem_en, 1);
                check("slot_we_h4", mem_we, 0);
                check("slot_addr_h4", mem_addr, 322);
            end
            if (h == 5) begin
                check("held_ready_h5", s_ready, 1);
                check("held_en_h5", mem_en, 1);
                check("held_we_h5", mem_we, 1);
                check("held_addr_h5", mem_addr, 17'h1ABCD);
                check("held_wdata_h5", mem_wdata, 16'h5A3C);
                $display("host write 1abcd <= 5a3c stalled at (4,2), accepted at (5,2)");
            end
        end
        for (int v = 3; v <= V_MAX; v++) begin
            if (v == 10) begin
                host_mode = 1;
                step(0, 10);
                host_mode = 2; f_addr = 17'h00123; f_data = 16'hBEEF; f_we = 1'b1;
                step(1, 10);
                check("host_ready_h1", s_ready, 1);
                check("host_en_h1", mem_en, 1);
                check("host_we_h1", mem_we, 1);
                check("host_addr_h1", mem_addr, 17'h00123);
                check("host_wdata_h1", mem_wdata, 16'hBEEF);
                $display("host write 00123 <= beef accepted at (1,10)");
                host_mode = 0;
                for (int h = 2; h <= 7; h++) step(h, 10);
                for (int h = H_MAX - 3; h <= H_MAX; h++) step(h, 10);
            end else begin
                host_mode = (v == 9 || v == V_DISPLAY - 1) ? 1 : 0;
                for (int h = H_MAX - 3; h <= H_MAX; h++) begin
                    step(h, v);
                    if (h == H_MAX - 3 && v == V_DISPLAY - 1) begin
                        check("ready_479_796", s_ready, 1);
                        check("nofetch_479_796", mem_en, 0);
                    end
                    if (h == H_MAX - 3 && v == V_MAX) begin
                        check("ready_524_796", s_ready, 0);
                        check("fetch_en_524", mem_en, 1);
                        check("fetch_we_524", mem_we, 0);
                        check("fetch_addr_524", mem_addr, 0);
                    end
                end
            end
        end
    endtask

    task automatic reset_cycles(input int h0, input int v);
        rst_n = 1'b0;
        host_mode = 2; f_addr = 17'h00777; f_data = 16'h1234; f_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(h0 + i, v);
            check("reset_ready_lit", s_ready, 0);
            check("reset_en_lit", mem_en, 0);
            check("reset_pix_lit", pix_out, 0);
        end
        rst_n = 1'b1;
        hold_req = 1'b0;
        host_mode = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = WORD_W'($urandom);
        ram[0] = 16'h3210;
        ram[1] = 16'h7654;
        ram[5] = 16'hA5A5;
        rst_n = 1'b0;
        hpos = 10'd300; vpos = 10'd10; display_on = 1'b0;
        host_valid = 1'b0; host_addr = '0; host_wdata = '0; host_we = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_cycles(300, 10);
        run_frame(0);
        run_frame(1);
        for (int h = 0; h <= H_MAX; h++) step(h, 0);
        for (int h = 0; h <= H_MAX; h++) step(h, 1);
        for (int h = 0; h < 300; h++) step(h, 2);
        reset_cycles(300, 2);
        run_frame(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
